// File: rtl/sub_gigante_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and out_ready; slave (the subtractor) returns the result.
interface sub_gigante_serial_if #(
  parameter int unsigned WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   D;
  logic             neg;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, D, neg
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, D, neg
  );
endinterface

// File: rtl/sub_gigante_serial.sv
// Bit-serial subtractor: D = A - B computed LSB-first, one bit per clock,
// returned as a (WIDTH+1)-bit two's-complement value with D[WIDTH] as the final borrow.
module sub_gigante_serial #(
  parameter int unsigned WIDTH = 9
) (
  input logic                clk,
  input logic                rst,
  sub_gigante_serial_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH:0]   d_q;
  logic             neg_q;

  logic d_bit;
  logic borrow_d;

  always_comb begin
    d_bit    = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      neg_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            sa_q       <= bus.A;
            sb_q       <= bus.B;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          res_q    <= {d_bit, res_q[WIDTH-1:1]};
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            // Last bit: publish the result from next-state values so DONE sees it at once.
            d_q         <= {borrow_d, d_bit, res_q[WIDTH-1:1]};
            neg_q       <= borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_sub_gigante_serial.sv
// Randomized self-checking bench for sub_gigante_serial against an arithmetic model.
module tb_sub_gigante_serial;

  localparam int unsigned WIDTH = 9;
  localparam int          MaxV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sub_gigante_serial_if #(.WIDTH(WIDTH)) bus ();

  sub_gigante_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected D: A - B as plain integer arithmetic, truncated to WIDTH+1 bits.
  function automatic logic [31:0] model_d(input int a, input int b);
    int diff;
    diff = a - b;
    return {22'd0, diff[WIDTH:0]};
  endfunction

  task automatic run_op(input int a, input int b, input int hold);
    int n;
    logic [31:0] exp_d;
    logic [31:0] exp_neg;
    exp_d   = model_d(a, b);
    exp_neg = (a < b) ? 32'd1 : 32'd0;
    @(negedge clk);
    bus.A         = a[WIDTH-1:0];
    bus.B         = b[WIDTH-1:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = WIDTH'($urandom);
    bus.B = WIDTH'($urandom);
    check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      // Stray in_valid and out_ready while busy must be ignored.
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.A = WIDTH'($urandom);
      @(negedge clk);
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("latency", n, WIDTH + 1);
    check("d", {22'd0, bus.D}, exp_d);
    check("neg", {31'd0, bus.neg}, exp_neg);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.A = WIDTH'($urandom);
      bus.B = WIDTH'($urandom);
      @(negedge clk);
      check("hold_d", {22'd0, bus.D}, exp_d);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_d", {22'd0, bus.D}, 32'd0);
    check("rst_neg", {31'd0, bus.neg}, 32'd0);
    rst = 1'b0;

    run_op(300, 45, 0);
    run_op(45, 300, 0);
    check("model_neg255", model_d(45, 300), 32'h301);
    run_op(0, MaxV, 0);
    run_op(MaxV, 0, 0);
    run_op(170, 170, 0);
    run_op(300, 45, 5);

    // Abort mid-operation: reset four cycles after accept.
    @(negedge clk);
    bus.A = 9'd100;
    bus.B = 9'd50;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_op(7, 3, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, MaxV)), int'($urandom_range(0, MaxV)),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
